// File: rtl/game_sequencer.sv
// game_sequencer: one guessing-game round sequencer, from master load to win/lose, with one credit per game
module game_sequencer #(
  parameter int MAX_ROUNDS = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       LoadMaster,
  input  logic       StartGame,
  input  logic       GradeIt,
  input  logic       creditAvail,
  input  logic       guessCorrect,
  output logic       masterLoaded,
  output logic       consumeGame,
  output logic [3:0] RoundNumber,
  output logic       inPlay,
  output logic       GameWon,
  output logic       GameOver
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOADED  = 3'd1;
  localparam logic [2:0] CONSUME = 3'd2;
  localparam logic [2:0] PLAY    = 3'd3;
  localparam logic [2:0] GRADE   = 3'd4;
  localparam logic [2:0] WON     = 3'd5;
  localparam logic [2:0] LOST    = 3'd6;
  localparam logic [3:0] MAXR    = 4'(MAX_ROUNDS);

  logic [2:0] state_q, state_d;
  logic [2:0] prev_q;
  logic [3:0] round_q, round_d;
  logic       correct_q, correct_d;
  logic       load_e, start_e, grade_e;

  // prev registers reset high so a level already asserted at reset release is not an edge
  assign {load_e, start_e, grade_e} = {LoadMaster, StartGame, GradeIt} & ~prev_q;

  // next-state: each state only looks at the one edge it cares about, others are dropped
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    correct_d = correct_q;
    case (state_q)
      IDLE:    state_d = load_e ? LOADED : IDLE;
      LOADED: if (start_e && creditAvail) begin
        state_d = CONSUME;
        round_d = 4'd1;
      end
      CONSUME: state_d = PLAY;
      PLAY: if (grade_e) begin
        state_d   = GRADE;
        correct_d = guessCorrect;
      end
      GRADE: if (correct_q) state_d = WON;
      else if (round_q >= MAXR) state_d = LOST;
      else begin
        state_d = PLAY;
        round_d = round_q + 4'd1;
      end
      WON, LOST: if (start_e) begin
        state_d = IDLE;
        round_d = 4'd0;
      end
      default: begin
        state_d   = IDLE;
        round_d   = 4'd0;
        correct_d = 1'b0;
      end
    endcase
  end

  // state, round and edge-history registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      round_q   <= 4'd0;
      correct_q <= 1'b0;
      prev_q    <= 3'b111;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      correct_q <= correct_d;
      prev_q    <= {LoadMaster, StartGame, GradeIt};
    end
  end

  // outputs decode only registered state; an illegal encoding reads as all-zero
  assign masterLoaded = state_q inside {LOADED, CONSUME, PLAY, GRADE, WON, LOST};
  assign consumeGame  = state_q == CONSUME;
  assign RoundNumber  = masterLoaded ? round_q : 4'd0;
  assign inPlay       = state_q inside {PLAY, GRADE};
  assign GameWon      = state_q == WON;
  assign GameOver     = state_q inside {WON, LOST};
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scoreboard bench for game_sequencer with directed vectors
module tb_game_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lm = 1'b0, sg = 1'b1, gi = 1'b0, ca = 1'b0, gc = 1'b0;
  logic       ml, cg, ip, gw, go;
  logic [3:0] rn;
  int         cyc = 0;
  int         tests = 0;
  int         failed = 0;
  bit         done = 1'b0;

  typedef struct {
    int         tag;
    logic [8:0] v;
    string      nm;
  } exp_t;
  exp_t q[$];

  game_sequencer #(.MAX_ROUNDS(8)) dut (
    .CLOCK_50(clk), .reset(reset), .LoadMaster(lm), .StartGame(sg), .GradeIt(gi),
    .creditAvail(ca), .guessCorrect(gc), .masterLoaded(ml), .consumeGame(cg),
    .RoundNumber(rn), .inPlay(ip), .GameWon(gw), .GameOver(go)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] o(input logic m, input logic c, input int r,
                                   input logic p, input logic w, input logic g);
    return {m, c, 4'(r), p, w, g};
  endfunction

  task automatic push(input string nm, input int tag, input logic [8:0] e);
    exp_t x;
    x.tag = tag;
    x.v   = e;
    x.nm  = nm;
    q.push_back(x);
  endtask

  // drive inputs for the next clock edge and queue the outputs expected after it
  task automatic drive(input string nm, input logic l, input logic s, input logic g,
                       input logic c, input logic k, input logic [8:0] e);
    @(negedge clk);
    lm = l; sg = s; gi = g; ca = c; gc = k;
    push(nm, cyc + 1, e);
  endtask

  // monitor: compare queued expectations against the DUT on the falling edge
  initial begin
    exp_t e;
    logic [8:0] act;
    int pulses = 0, doubles = 0;
    logic prev_cg = 1'b0;
    forever begin
      @(negedge clk);
      act = {ml, cg, rn, ip, gw, go};
      if (cg) pulses++;
      if (cg && prev_cg) doubles++;
      prev_cg = cg;
      while (q.size() > 0 && q[0].tag <= cyc) begin
        e = q.pop_front();
        tests++;
        if (e.tag != cyc || act !== e.v) begin
          failed++;
          $display("FAIL %s: got %b required %b (tag %0d cyc %0d)", e.nm, act, e.v, e.tag, cyc);
        end
      end
      if (done && q.size() == 0) break;
      if (cyc > 5000) begin
        failed++;
        $display("FAIL timeout: %0d expectations pending", q.size());
        break;
      end
    end
    tests++;
    if (pulses != 3) begin
      failed++;
      $display("FAIL consume_count: got %0d required 3", pulses);
    end
    tests++;
    if (doubles != 0) begin
      failed++;
      $display("FAIL consume_double: got %0d required 0", doubles);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // stimulus
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive("rst_start_held0", 0, 1, 0, 0, 0, o(0,0,0,0,0,0));
    drive("rst_start_held1", 0, 1, 0, 0, 0, o(0,0,0,0,0,0));
    drive("load",            1, 1, 0, 0, 0, o(1,0,0,0,0,0));
    drive("loaded_hold",     0, 0, 0, 0, 0, o(1,0,0,0,0,0));
    drive("start_nocredit",  0, 1, 0, 0, 0, o(1,0,0,0,0,0));
    drive("nocredit_hold",   0, 0, 0, 0, 0, o(1,0,0,0,0,0));
    drive("consume",         0, 1, 0, 1, 0, o(1,1,1,0,0,0));
    drive("play_r1",         0, 0, 0, 1, 0, o(1,0,1,1,0,0));
    drive("play_r1_hold",    0, 0, 0, 1, 0, o(1,0,1,1,0,0));
    drive("grade1",          0, 0, 1, 1, 0, o(1,0,1,1,0,0));
    drive("play_r2",         0, 0, 0, 1, 0, o(1,0,2,1,0,0));
    drive("grade2",          0, 0, 1, 1, 0, o(1,0,2,1,0,0));
    drive("play_r3",         0, 0, 0, 1, 0, o(1,0,3,1,0,0));
    drive("grade3_ok",       0, 0, 1, 1, 1, o(1,0,3,1,0,0));
    drive("won",             0, 0, 0, 1, 0, o(1,0,3,0,1,1));
    drive("won_hold",        1, 0, 0, 1, 0, o(1,0,3,0,1,1));
    drive("won_to_idle",     0, 1, 0, 1, 0, o(0,0,0,0,0,0));
    drive("idle_after_win",  0, 0, 0, 1, 0, o(0,0,0,0,0,0));
    drive("g2_load",         1, 0, 0, 1, 0, o(1,0,0,0,0,0));
    drive("g2_consume",      0, 1, 0, 1, 0, o(1,1,1,0,0,0));
    drive("g2_play",         0, 0, 0, 1, 0, o(1,0,1,1,0,0));
    drive("g2_simul_edges",  1, 1, 1, 1, 0, o(1,0,1,1,0,0));
    drive("g2_grade_held",   0, 0, 1, 1, 0, o(1,0,2,1,0,0));
    drive("g2_play_r2",      0, 0, 0, 1, 0, o(1,0,2,1,0,0));
    for (int r = 2; r <= 8; r++) begin
      drive($sformatf("g2_grade_r%0d", r), 0, 0, 1, 1, 0, o(1,0,r,1,0,0));
      drive($sformatf("g2_after_r%0d", r), 0, 0, 0, 1, 0,
            r < 8 ? o(1,0,r+1,1,0,0) : o(1,0,8,0,0,1));
    end
    drive("lost_hold",       0, 0, 1, 1, 1, o(1,0,8,0,0,1));
    drive("lost_to_idle",    0, 1, 0, 1, 0, o(0,0,0,0,0,0));
    drive("g3_load",         1, 0, 0, 1, 0, o(1,0,0,0,0,0));
    drive("g3_consume",      0, 1, 0, 1, 0, o(1,1,1,0,0,0));
    drive("g3_play",         0, 0, 0, 1, 0, o(1,0,1,1,0,0));
    for (int r = 1; r <= 4; r++) begin
      drive($sformatf("g3_grade_r%0d", r), 0, 0, 1, 1, 0, o(1,0,r,1,0,0));
      drive($sformatf("g3_after_r%0d", r), 0, 0, 0, 1, 0, o(1,0,r+1,1,0,0));
    end
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    push("async_reset", cyc, o(0,0,0,0,0,0));
    @(negedge clk);
    reset = 1'b0;
    drive("post_rst_idle",   0, 0, 0, 1, 0, o(0,0,0,0,0,0));
    drive("post_rst_start",  0, 1, 0, 1, 0, o(0,0,0,0,0,0));
    drive("post_rst_idle2",  0, 0, 0, 1, 0, o(0,0,0,0,0,0));
    drive("post_rst_load",   1, 0, 0, 1, 0, o(1,0,0,0,0,0));
    drive("post_rst_loaded", 0, 0, 0, 1, 0, o(1,0,0,0,0,0));
    @(negedge clk);
    done = 1'b1;
  end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller for the coin-operated guessing game. It sequences one game from master-pattern load through up to MAX_ROUNDS graded guesses to a win/lose result. It consumes exactly one game credit per started game through a single-cycle pulse to the credit counter. RoundNumber and masterLoaded from this block gate the coin/credit logic; creditAvail comes back from it.

## Interface
- MAX_ROUNDS, 8: guesses allowed per game; legal range 1..15.

- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- LoadMaster  in  1  level; its rising edge latches "master pattern present".
- StartGame  in  1  level; its rising edge requests a new game.
- GradeIt  in  1  level; its rising edge submits the current guess.
- creditAvail  in  1  high when the credit count is non-zero.
- guessCorrect  in  1  combinational grade of the current guess; sampled on the GradeIt edge.
- masterLoaded  out  1  master pattern held for the pending or current game.
- consumeGame  out  1  one-cycle pulse; the credit counter decrements by 1.
- RoundNumber  out  4  0 when no game is running, else 1..MAX_ROUNDS.
- inPlay  out  1  high in PLAY and GRADE.
- GameWon  out  1  high in WON.
- GameOver  out  1  high in WON and LOST.

## Operation
- Edge detect: one prev register per level input (LoadMaster, StartGame, GradeIt). Each prev register resets to 1, so an input held high through reset never fires. edge = in & ~prev.
- States: IDLE, LOADED, CONSUME, PLAY, GRADE, WON, LOST. Reset state is IDLE.
- IDLE: on a LoadMaster edge, go to LOADED.
- LOADED: on a StartGame edge with creditAvail=1, go to CONSUME. A StartGame edge with creditAvail=0 is ignored and the state stays LOADED.
- CONSUME: lasts exactly one cycle. consumeGame=1 and RoundNumber loads 1. Unconditionally go to PLAY.
- PLAY: on a GradeIt edge, go to GRADE and capture guessCorrect into a register.
- GRADE: lasts exactly one cycle.
  - If the captured result is 1, go to WON.
  - Else if RoundNumber==MAX_ROUNDS, go to LOST.
  - Else increment RoundNumber and go to PLAY.
- WON / LOST: hold until a StartGame edge. Then go to IDLE, clearing RoundNumber to 0 and masterLoaded to 0.
- masterLoaded is 1 in LOADED, CONSUME, PLAY, GRADE, WON and LOST; it is 0 only in IDLE.
- Ignored events:
  - LoadMaster edges in every state except IDLE.
  - GradeIt edges outside PLAY.
  - StartGame edges in IDLE, CONSUME, PLAY and GRADE.
- Simultaneous edges: only the edge relevant to the current state acts; all others are dropped, not queued.
- RoundNumber arithmetic: 4-bit unsigned. It never exceeds MAX_ROUNDS and never wraps, because the bound is checked before the increment.
- Illegal state encodings: recover to IDLE with all outputs at reset values.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from any input to any output.
- Reset values: masterLoaded=0, consumeGame=0, RoundNumber=0, inPlay=0, GameWon=0, GameOver=0.
- Reset asserted mid-game: all outputs return to their reset values immediately (asynchronously). No consumeGame pulse is issued. Any credit already consumed is not refunded.
- An input edge seen at clock edge k changes the state at edge k. The resulting output is visible after edge k.
- StartGame edge to consumeGame: consumeGame is high for exactly the one cycle after edge k. RoundNumber=1 is visible in that same cycle.
- GradeIt edge to result: the GRADE cycle follows edge k, and the new RoundNumber or WON/LOST appears after edge k+1. Latency is 2 cycles.
- Input rate: consecutive GradeIt edges need at least 2 cycles between them. An edge arriving during GRADE is dropped.
- consumeGame is never high for 2 consecutive cycles. It pulses at most once per game.

## Test plan
- Reset release with StartGame=1 held high: no transition occurs and all outputs stay 0. A later LoadMaster edge moves to LOADED (masterLoaded=1).
- LOADED with creditAvail=0, StartGame edge: no consumeGame pulse and the state stays LOADED. Then creditAvail=1 and a StartGame edge: one consumeGame pulse, RoundNumber=1, inPlay=1.
- MAX_ROUNDS=8, 3 graded guesses with guessCorrect=0,0,1: RoundNumber steps 1→2→3, then GameWon=1 and GameOver=1 with RoundNumber held at 3. A StartGame edge then gives RoundNumber=0 and masterLoaded=0.
- 8 incorrect guesses: RoundNumber reaches 8, then the state is LOST (GameOver=1, GameWon=0). RoundNumber never reads 9.
- During PLAY, apply LoadMaster and StartGame edges together with a GradeIt edge: only the grade acts, and no extra consumeGame pulse occurs. Also apply a GradeIt edge during GRADE: it is dropped.
- Assert reset while in PLAY at round 5: outputs clear asynchronously, and the block returns to IDLE requiring a new LoadMaster edge.
